md_audio_mixer: RTL

Parametrised, time-multiplexed stereo audio mixer for the Mega Drive board top level. It replaces the fixed two-source summation of FM and PSG with an N-channel mixer that provides per-channel left/right gain, per-channel offset-binary conversion, saturation and overrun detection. It sits between the sound sources (FM linear output, FM DAC-emulation output, PSG, and future expansion sources) and the board audio outputs. Each channel is processed in one MCLK cycle through a single shared multiply-accumulate path.

---
 rtl/md_audio_mixer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/md_audio_mixer.sv
// N-channel time-multiplexed stereo mixer: one channel per MCLK through a shared
// MAC, per-channel L/R gain, offset-binary conversion, saturation and overrun flag.
//
// state | meaning
// IDLE  | waiting for a sample_in strobe
// ACC   | accumulating channel idx into acc_l/acc_r
// OUT   | scaling, saturating and registering the mix result
module md_audio_mixer #(
   parameter int NCH = 4,
   parameter int IW  = 16,
   parameter int GW  = 8,
   parameter int GF  = 6,
   parameter int OW  = 16,
   parameter logic [NCH-1:0] OFFSET_MASK = '0
) (
   input  logic                    MCLK,
   input  logic                    reset,
   input  logic [NCH*IW-1:0]       ch_data,
   input  logic                    sample_in,
   input  logic                    mute,
   input  logic                    gain_wr,
   input  logic [$clog2(NCH):0]    gain_sel,
   input  logic [GW-1:0]           gain_data,
   input  logic                    ovr_clr,
   output logic signed [OW-1:0]    out_l,
   output logic signed [OW-1:0]    out_r,
   output logic                    out_valid,
   output logic                    busy,
   output logic                    overrun
);
   localparam int SW = $clog2(NCH) + 1;
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW = IW + GW + 1;
   localparam int AW = PW + $clog2(NCH);
   localparam logic [GW-1:0] UNITY = GW'(1) << GF;
   localparam logic [IW-1:0] MSB_FLIP = {1'b1, {(IW-1){1'b0}}};
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;
   state_t state, state_nx;

   logic                  accept, acc_en, out_ld;
   logic [CW-1:0]         idx;
   logic                  idx_last;
   logic signed [AW-1:0]  acc_l, acc_r;
   logic signed [PW-1:0]  prod_l, prod_r;
   logic signed [IW-1:0]  conv  [NCH];
   logic signed [IW-1:0]  x_lat [NCH];
   logic [GW-1:0]         gl [NCH], gr [NCH], sgl [NCH], sgr [NCH];
   logic                  mute_lat;
   logic [SW-1:0]         sel_shift;
   logic                  sel_ok;
   logic [CW-1:0]         sel_ch;

   assign sel_shift = gain_sel >> 1;
   assign sel_ok    = (sel_shift < SW'(NCH));
   assign sel_ch    = sel_shift[CW-1:0];
   assign idx_last  = (idx == CW'(NCH-1));

   always_ff @(posedge MCLK or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b1;
      accept   = 1'b0;
      acc_en   = 1'b0;
      out_ld   = 1'b0;
      case (state)
         S_IDLE: begin
            busy   = 1'b0;
            accept = sample_in;
            if (sample_in) state_nx = S_ACC;
         end
         S_ACC: begin
            acc_en = 1'b1;
            if (idx_last) state_nx = S_OUT;
         end
         S_OUT: begin
            out_ld   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Offset-binary channels: subtracting 2^(IW-1) is the same as flipping the MSB.
   always_comb begin
      for (int k = 0; k < NCH; k++)
         conv[k] = $signed(ch_data[k*IW +: IW] ^ (OFFSET_MASK[k] ? MSB_FLIP : '0));
   end

   assign prod_l = PW'(x_lat[idx]) * PW'($signed({1'b0, sgl[idx]}));
   assign prod_r = PW'(x_lat[idx]) * PW'($signed({1'b0, sgr[idx]}));

   function automatic logic signed [OW-1:0] scale_sat(input logic signed [AW-1:0] a);
      logic signed [AW-1:0] s;
      s = a >>> GF;
      if (s > SAT_MAX)      return SAT_MAX[OW-1:0];
      else if (s < SAT_MIN) return SAT_MIN[OW-1:0];
      else                  return s[OW-1:0];
   endfunction

   always_ff @(posedge MCLK or posedge reset) begin
      if (reset) begin
         idx       <= '0;
         acc_l     <= '0;
         acc_r     <= '0;
         mute_lat  <= 1'b0;
         out_l     <= '0;
         out_r     <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            gl[k]    <= UNITY;
            gr[k]    <= UNITY;
            sgl[k]   <= UNITY;
            sgr[k]   <= UNITY;
            x_lat[k] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         if (gain_wr && sel_ok) begin
            if (gain_sel[0]) gr[sel_ch] <= gain_data;
            else             gl[sel_ch] <= gain_data;
         end
         // Shadow copy takes the pre-write gains when a write coincides with the strobe.
         if (accept) begin
            for (int k = 0; k < NCH; k++) begin
               x_lat[k] <= conv[k];
               sgl[k]   <= gl[k];
               sgr[k]   <= gr[k];
            end
            acc_l    <= '0;
            acc_r    <= '0;
            idx      <= '0;
            mute_lat <= mute;
         end
         if (acc_en) begin
            acc_l <= acc_l + AW'(prod_l);
            acc_r <= acc_r + AW'(prod_r);
            idx   <= idx + 1'b1;
         end
         if (out_ld) begin
            out_l     <= mute_lat ? '0 : scale_sat(acc_l);
            out_r     <= mute_lat ? '0 : scale_sat(acc_r);
            out_valid <= 1'b1;
         end
         if (sample_in && busy) overrun <= 1'b1;
         else if (ovr_clr)      overrun <= 1'b0;
      end
   end
endmodule
